// File: rtl/hazard_ctrl.sv
// Pipeline hazard and forwarding controller for the 5-stage core.
// Produces stall/bubble/flush controls, EX operand forwarding selects, the
// taken-branch PC redirect, saturating performance counters and a sticky
// memory-wait timeout flag. Controls are combinational from state + inputs.
module hazard_ctrl #(
  parameter int unsigned RFIDX_WIDTH = 5,
  parameter int unsigned PC_SIZE     = 32,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [RFIDX_WIDTH-1:0] id_rs1_index,
  input  logic [RFIDX_WIDTH-1:0] id_rs2_index,
  input  logic                   id_rs1_used,
  input  logic                   id_rs2_used,
  input  logic [RFIDX_WIDTH-1:0] ex_rs1_index,
  input  logic [RFIDX_WIDTH-1:0] ex_rs2_index,
  input  logic [RFIDX_WIDTH-1:0] ex_rd_index,
  input  logic                   ex_mem_read,
  input  logic                   ex_reg_write,
  input  logic                   ex_branch_taken,
  input  logic [PC_SIZE-1:0]     ex_branch_target,
  input  logic [RFIDX_WIDTH-1:0] mem_rd_index,
  input  logic                   mem_reg_write,
  input  logic [RFIDX_WIDTH-1:0] wb_rd_index,
  input  logic                   wb_reg_write,
  input  logic                   mem_busy,
  input  logic                   cnt_clr,
  output logic                   pc_stall,
  output logic                   if_id_stall,
  output logic                   if_id_flush,
  output logic                   id_ex_stall,
  output logic                   id_ex_bubble,
  output logic                   ex_mem_stall,
  output logic [1:0]             fwd_a_sel,
  output logic [1:0]             fwd_b_sel,
  output logic                   redirect_valid,
  output logic [PC_SIZE-1:0]     redirect_pc,
  output logic [CNT_W-1:0]       stall_cycles,
  output logic [CNT_W-1:0]       flush_events,
  output logic                   mem_timeout_err
);

  // Timeout counter is wide enough to hold MEM_TIMEOUT and saturates there.
  localparam int unsigned TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0]    TMAX    = TW'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {StRun, StLstall, StMwait, StFlushed} state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             err_q, err_d;

  logic load_use;
  logic branch_ok;
  logic lu_ok;

  // MWAIT without busy behaves as RUN, so only FLUSHED masks the branch and
  // only LSTALL masks a repeated load-use.
  assign load_use = ex_mem_read && ex_reg_write && (ex_rd_index != '0) &&
                    ((id_rs1_used && (id_rs1_index == ex_rd_index)) ||
                     (id_rs2_used && (id_rs2_index == ex_rd_index)));
  assign branch_ok = ex_branch_taken && (state_q != StFlushed);
  assign lu_ok     = load_use && (state_q != StLstall);

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
      tcnt_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      err_q   <= err_d;
    end
  end

  // Next-state selection; priority is mem_busy, then branch, then load-use.
  always_comb begin
    state_d = StRun;
    if (mem_busy) begin
      state_d = StMwait;
    end else if (branch_ok) begin
      state_d = StFlushed;
    end else if (lu_ok) begin
      state_d = StLstall;
    end
  end

  // Control outputs, forced to zero while reset is asserted.
  always_comb begin
    pc_stall       = 1'b0;
    if_id_stall    = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_stall    = 1'b0;
    id_ex_bubble   = 1'b0;
    ex_mem_stall   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    fwd_a_sel      = 2'b00;
    fwd_b_sel      = 2'b00;
    if (rst_n) begin
      if (mem_busy) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
      end else if (branch_ok) begin
        redirect_valid = 1'b1;
        redirect_pc    = ex_branch_target;
        if_id_flush    = 1'b1;
        id_ex_bubble   = 1'b1;
      end else if (lu_ok) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_bubble = 1'b1;
      end

      if (mem_reg_write && (mem_rd_index != '0) && (mem_rd_index == ex_rs1_index)) begin
        fwd_a_sel = 2'b01;
      end else if (wb_reg_write && (wb_rd_index != '0) && (wb_rd_index == ex_rs1_index)) begin
        fwd_a_sel = 2'b10;
      end

      if (mem_reg_write && (mem_rd_index != '0) && (mem_rd_index == ex_rs2_index)) begin
        fwd_b_sel = 2'b01;
      end else if (wb_reg_write && (wb_rd_index != '0) && (wb_rd_index == ex_rs2_index)) begin
        fwd_b_sel = 2'b10;
      end
    end
  end

  // Counter, timeout and sticky error next-state; cnt_clr beats increment.
  always_comb begin
    tcnt_d  = '0;
    stall_d = stall_q;
    flush_d = flush_q;
    err_d   = err_q;
    if (mem_busy) begin
      tcnt_d = (tcnt_q == TMAX) ? tcnt_q : tcnt_q + TW'(1);
    end
    if (cnt_clr) begin
      stall_d = '0;
      flush_d = '0;
      err_d   = 1'b0;
    end else begin
      if (pc_stall && (stall_q != CNT_MAX)) begin
        stall_d = stall_q + CNT_W'(1);
      end
      if (redirect_valid && (flush_q != CNT_MAX)) begin
        flush_d = flush_q + CNT_W'(1);
      end
      // Set on the edge where the busy run reaches MEM_TIMEOUT cycles.
      if (mem_busy && (tcnt_d == TMAX)) begin
        err_d = 1'b1;
      end
    end
  end

  assign stall_cycles    = stall_q;
  assign flush_events    = flush_q;
  assign mem_timeout_err = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver applies stimulus and queues the
// reference model's expected outputs; a monitor pops and compares each cycle.
module tb_hazard_ctrl;

  localparam int unsigned RW = 5;
  localparam int unsigned PW = 32;
  localparam int unsigned CW = 4;
  localparam int unsigned TO = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [RW-1:0] id_rs1_index, id_rs2_index, ex_rs1_index, ex_rs2_index, ex_rd_index;
  logic [RW-1:0] mem_rd_index, wb_rd_index;
  logic          id_rs1_used, id_rs2_used, ex_mem_read, ex_reg_write, ex_branch_taken;
  logic [PW-1:0] ex_branch_target;
  logic          mem_reg_write, wb_reg_write, mem_busy, cnt_clr;
  logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, ex_mem_stall;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          redirect_valid;
  logic [PW-1:0] redirect_pc;
  logic [CW-1:0] stall_cycles, flush_events;
  logic          mem_timeout_err;

  hazard_ctrl #(
    .RFIDX_WIDTH(RW), .PC_SIZE(PW), .CNT_W(CW), .MEM_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_index(id_rs1_index), .id_rs2_index(id_rs2_index),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rs1_index(ex_rs1_index), .ex_rs2_index(ex_rs2_index), .ex_rd_index(ex_rd_index),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .mem_rd_index(mem_rd_index), .mem_reg_write(mem_reg_write),
    .wb_rd_index(wb_rd_index), .wb_reg_write(wb_reg_write),
    .mem_busy(mem_busy), .cnt_clr(cnt_clr),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_bubble(id_ex_bubble), .ex_mem_stall(ex_mem_stall),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_cycles(stall_cycles), .flush_events(flush_events),
    .mem_timeout_err(mem_timeout_err)
  );

  typedef struct packed {
    logic          rst_n;
    logic [RW-1:0] rs1, rs2;
    logic          rs1_used, rs2_used;
    logic [RW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic          mem_read, reg_write, br;
    logic [PW-1:0] tgt;
    logic [RW-1:0] mem_rd;
    logic          mem_w;
    logic [RW-1:0] wb_rd;
    logic          wb_w, busy, clr;
  } stim_t;

  typedef struct packed {
    logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, ex_mem_stall;
    logic          redirect;
    logic [PW-1:0] rpc;
    logic [1:0]    fa, fb;
    int            sc, fe;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: a busy-run length plus two "what just happened" flags.
  int busy_run = 0;
  bit bubble_in_ex = 0;  // last cycle redirected, EX now holds a bubble
  bit just_stalled = 0;  // last cycle already inserted the load-use bubble
  int m_sc = 0, m_fe = 0;
  bit m_err = 0;

  function automatic logic [1:0] fwd(input stim_t s, input logic [RW-1:0] src);
    if (s.mem_w && s.mem_rd != 0 && s.mem_rd == src) return 2'b01;
    if (s.wb_w && s.wb_rd != 0 && s.wb_rd == src) return 2'b10;
    return 2'b00;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit   lu;
    @(posedge clk);
    #2;
    rst_n = s.rst_n; id_rs1_index = s.rs1; id_rs2_index = s.rs2;
    id_rs1_used = s.rs1_used; id_rs2_used = s.rs2_used;
    ex_rs1_index = s.ex_rs1; ex_rs2_index = s.ex_rs2; ex_rd_index = s.ex_rd;
    ex_mem_read = s.mem_read; ex_reg_write = s.reg_write;
    ex_branch_taken = s.br; ex_branch_target = s.tgt;
    mem_rd_index = s.mem_rd; mem_reg_write = s.mem_w;
    wb_rd_index = s.wb_rd; wb_reg_write = s.wb_w;
    mem_busy = s.busy; cnt_clr = s.clr;

    e = '0;
    if (s.rst_n) begin
      e.fa = fwd(s, s.ex_rs1);
      e.fb = fwd(s, s.ex_rs2);
      lu = s.mem_read && s.reg_write && s.ex_rd != 0 &&
           ((s.rs1_used && s.rs1 == s.ex_rd) || (s.rs2_used && s.rs2 == s.ex_rd));
      if (s.busy) begin
        e.pc_stall = 1; e.if_id_stall = 1; e.id_ex_stall = 1; e.ex_mem_stall = 1;
      end else if (s.br && !bubble_in_ex) begin
        e.redirect = 1; e.rpc = s.tgt; e.if_id_flush = 1; e.id_ex_bubble = 1;
      end else if (lu && !just_stalled) begin
        e.pc_stall = 1; e.if_id_stall = 1; e.id_ex_bubble = 1;
      end
    end
    e.sc = m_sc; e.fe = m_fe; e.err = m_err;
    exp_q.push_back(e);

    // Effect of the coming clock edge on the model.
    if (!s.rst_n) begin
      busy_run = 0; bubble_in_ex = 0; just_stalled = 0; m_sc = 0; m_fe = 0; m_err = 0;
    end else begin
      if (s.busy) begin
        busy_run++;
        bubble_in_ex = 0; just_stalled = 0;
      end else begin
        busy_run = 0;
        bubble_in_ex = e.redirect;
        just_stalled = e.pc_stall;
      end
      if (s.clr) begin
        m_sc = 0; m_fe = 0; m_err = 0;
      end else begin
        if (e.pc_stall && m_sc < CMAX) m_sc++;
        if (e.redirect && m_fe < CMAX) m_fe++;
        if (s.busy && busy_run >= TO) m_err = 1;
      end
    end
  endtask

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_stall", pc_stall, e.pc_stall);
        chk("if_id_stall", if_id_stall, e.if_id_stall);
        chk("if_id_flush", if_id_flush, e.if_id_flush);
        chk("id_ex_stall", id_ex_stall, e.id_ex_stall);
        chk("id_ex_bubble", id_ex_bubble, e.id_ex_bubble);
        chk("ex_mem_stall", ex_mem_stall, e.ex_mem_stall);
        chk("redirect_valid", redirect_valid, e.redirect);
        chk("redirect_pc", redirect_pc, e.rpc);
        chk("fwd_a_sel", fwd_a_sel, e.fa);
        chk("fwd_b_sel", fwd_b_sel, e.fb);
        chk("stall_cycles", stall_cycles, e.sc);
        chk("flush_events", flush_events, e.fe);
        chk("mem_timeout_err", mem_timeout_err, e.err);
      end
    end
  end

  initial begin
    stim_t s, idle;
    int    burst;
    idle = '0;
    idle.rst_n = 1;

    // Reset.
    s = '0;
    apply(s); apply(s);

    // Load-use on x5: one stall cycle, then nothing.
    s = idle; s.mem_read = 1; s.reg_write = 1; s.ex_rd = 5; s.rs1 = 5; s.rs1_used = 1;
    apply(s); apply(s);
    apply(idle);

    // Taken branch with a concurrent load-use; held branch next cycle ignored.
    s.br = 1; s.tgt = 32'h0000_0100;
    apply(s);
    s.mem_read = 0;
    apply(s);
    apply(idle);

    // Forwarding: MEM wins, then WB, x0 never forwards.
    s = idle; s.mem_rd = 3; s.mem_w = 1; s.wb_rd = 3; s.wb_w = 1; s.ex_rs1 = 3; s.ex_rs2 = 0;
    apply(s);
    s.mem_w = 0;
    apply(s);
    s.mem_rd = 0; s.mem_w = 1; s.ex_rs2 = 0; s.wb_rd = 0;
    apply(s);

    // Memory wait holds a taken branch, redirect on the release cycle.
    s = idle; s.br = 1; s.tgt = 32'hDEAD_BEE0; s.busy = 1;
    repeat (4) apply(s);
    s.busy = 0;
    apply(s);
    apply(idle);

    // Timeout: busy for 5 cycles, flag sticks, cnt_clr clears everything.
    s = idle; s.busy = 1;
    repeat (5) apply(s);
    apply(idle); apply(idle);
    s = idle; s.clr = 1;
    apply(s);
    apply(idle);

    // Reset during LSTALL leaves nothing pending.
    s = idle; s.mem_read = 1; s.reg_write = 1; s.ex_rd = 7; s.rs2 = 7; s.rs2_used = 1;
    apply(s);
    s.rst_n = 0;
    apply(s);
    apply(idle); apply(idle);

    // Randomized traffic with occasional busy bursts, clears and resets.
    burst = 0;
    for (int i = 0; i < 2000; i++) begin
      s.rst_n     = ($urandom_range(0, 99) != 0);
      s.rs1       = RW'($urandom_range(0, 3));
      s.rs2       = RW'($urandom_range(0, 3));
      s.rs1_used  = 1'($urandom);
      s.rs2_used  = 1'($urandom);
      s.ex_rs1    = RW'($urandom_range(0, 3));
      s.ex_rs2    = RW'($urandom_range(0, 3));
      s.ex_rd     = RW'($urandom_range(0, 3));
      s.mem_read  = ($urandom_range(0, 2) != 0);
      s.reg_write = ($urandom_range(0, 3) != 0);
      s.br        = ($urandom_range(0, 3) == 0);
      s.tgt       = $urandom;
      s.mem_rd    = RW'($urandom_range(0, 3));
      s.mem_w     = 1'($urandom);
      s.wb_rd     = RW'($urandom_range(0, 3));
      s.wb_w      = 1'($urandom);
      s.clr       = ($urandom_range(0, 39) == 0);
      if (burst > 0) begin
        s.busy = 1; burst--;
      end else if ($urandom_range(0, 7) == 0) begin
        s.busy = 1; burst = $urandom_range(0, 5);
      end else begin
        s.busy = 0;
      end
      apply(s);
    end

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and forwarding controller for the 5-stage core. It reads the EX-side outputs of the ID/EX register, the decode-side source indices, and the MEM and WB destination fields. It drives stall, bubble and flush controls for the IF/ID, ID/EX and EX/MEM registers, and the EX operand forwarding selects. It also issues the branch redirect to the PC, counts stall cycles and flush events, and times out on memory waits.

Parameters:
RFIDX_WIDTH, 5, register index width
PC_SIZE, 32, PC width
CNT_W, 16, width of performance counters (saturating)
MEM_TIMEOUT, 255, max consecutive mem_busy cycles before error

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
id_rs1_index  in  RFIDX_WIDTH  decode rs1
id_rs2_index  in  RFIDX_WIDTH  decode rs2
id_rs1_used  in  1  decode instr reads rs1
id_rs2_used  in  1  decode instr reads rs2
ex_rs1_index  in  RFIDX_WIDTH  ID/EX rs1_index_out
ex_rs2_index  in  RFIDX_WIDTH  ID/EX rs2_index_out
ex_rd_index  in  RFIDX_WIDTH  ID/EX rd_index_out
ex_mem_read  in  1  ID/EX m_mem_read_out
ex_reg_write  in  1  ID/EX wb_reg_write_out
ex_branch_taken  in  1  branch/jump resolved taken in EX
ex_branch_target  in  PC_SIZE  resolved target
mem_rd_index  in  RFIDX_WIDTH  EX/MEM rd
mem_reg_write  in  1  EX/MEM reg write
wb_rd_index  in  RFIDX_WIDTH  MEM/WB rd
wb_reg_write  in  1  MEM/WB reg write
mem_busy  in  1  data memory not ready
cnt_clr  in  1  clear counters and error
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  zero IF/ID
id_ex_stall  out  1  hold ID/EX
id_ex_bubble  out  1  load NOP into ID/EX
ex_mem_stall  out  1  hold EX/MEM
fwd_a_sel  out  2  EX operand A: 00 regfile, 01 MEM, 10 WB
fwd_b_sel  out  2  EX operand B, same encoding
redirect_valid  out  1  load PC with redirect_pc
redirect_pc  out  PC_SIZE  redirect target
stall_cycles  out  CNT_W  cycles with pc_stall=1
flush_events  out  CNT_W  redirect count
mem_timeout_err  out  1  sticky timeout flag

Behaviour:
- States: RUN, LSTALL, MWAIT, FLUSHED. Reset (rst_n=0 at clk edge) -> RUN, counters 0, timeout counter 0, mem_timeout_err 0. All control outputs are 0 and redirect_pc is 0 while rst_n=0. Reset mid-stall returns to RUN with no pending action.
- Control outputs are combinational from state plus inputs: zero latency, same-cycle effect. The next state and counters update at the clk edge.
- Priority per cycle: mem_busy > ex_branch_taken > load-use.
- mem_busy=1 in any state: pc_stall, if_id_stall, id_ex_stall and ex_mem_stall are 1. No flush, bubble or redirect. Next state is MWAIT. The timeout counter increments. When it reaches MEM_TIMEOUT, mem_timeout_err is set and stays set until cnt_clr or reset.
- MWAIT with mem_busy=0: evaluate as RUN in the same cycle. Timeout counter cleared. A branch held in EX during the wait is acted on now.
- Branch (RUN/LSTALL, ex_branch_taken=1, mem_busy=0): redirect_valid=1, redirect_pc=ex_branch_target, if_id_flush=1, id_ex_bubble=1, no stall. Next state FLUSHED. Load-use is ignored that cycle.
- FLUSHED: ex_branch_taken is ignored because EX holds a bubble. Load-use is evaluated normally. Returns to RUN.
- Load-use (RUN/FLUSHED only): true when ex_mem_read=1, ex_reg_write=1 and ex_rd_index!=0, and either (id_rs1_used and id_rs1_index==ex_rd_index) or (id_rs2_used and id_rs2_index==ex_rd_index). Then pc_stall=1, if_id_stall=1, id_ex_bubble=1, and next state is LSTALL.
- LSTALL: load-use is not re-asserted. Exactly one bubble per load. Next state RUN.
- Forwarding is combinational and independent of state.
  - A: 01 if mem_reg_write=1, mem_rd_index!=0 and mem_rd_index==ex_rs1_index.
  - Else 10 if the same condition holds for WB.
  - Else 00.
  - MEM wins over WB. Index 0 never forwards. B is identical using ex_rs2_index.
- Counters:
  - stall_cycles +1 each cycle pc_stall=1.
  - flush_events +1 each cycle redirect_valid=1.
  - Both saturate at all-ones.
  - cnt_clr=1 zeros both and mem_timeout_err at the next edge, taking precedence over increment that cycle.

Test Plan:
- Reset then load x5 in EX (ex_mem_read=1, ex_reg_write=1, rd=5), decode rs1=5 used -> one cycle pc_stall/if_id_stall/id_ex_bubble=1, next cycle all 0, stall_cycles=1.
- ex_branch_taken=1, target=0x0000_0100, concurrent load-use -> redirect_valid=1, redirect_pc=0x100, if_id_flush=1, no stall; next cycle ex_branch_taken held 1 is ignored, flush_events=1.
- mem_rd=3 write, wb_rd=3 write, ex_rs1=3, ex_rs2=0 -> fwd_a_sel=01, fwd_b_sel=00; mem_reg_write=0 -> fwd_a_sel=10.
- mem_busy=1 for 4 cycles with ex_branch_taken=1 -> all four stalls 1 and no redirect for 4 cycles; on the cycle mem_busy drops, redirect_valid=1.
- MEM_TIMEOUT=3, mem_busy held 5 cycles -> mem_timeout_err=1 after the 3rd, stays 1 after busy drops; cnt_clr -> err=0, counters=0.
- rst_n=0 during LSTALL -> outputs 0; after release, no residual bubble and state RUN.
